// File: rtl/ysyx_040066_clint_pkg.sv
// Shared definitions for the ysyx_040066 CLINT: register offsets inside the
// 64 KiB window, the mtimecmp reset value, the register decode enum and
// helpers for address decode and byte-masked merges.
package ysyx_040066_clint_pkg;

  // Register offsets; only bits [15:3] take part in decode.
  localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
  localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

  // mtimecmp powers up at its maximum so no timer interrupt fires until
  // software programs a real deadline.
  localparam logic [63:0] CLINT_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    REG_MSIP     = 2'd0,
    REG_MTIMECMP = 2'd1,
    REG_MTIME    = 2'd2,
    REG_NONE     = 2'd3
  } clint_reg_e;

  // Byte lane within the doubleword is ignored, so any offset inside an
  // 8-byte slot selects the same register.
  function automatic clint_reg_e decodeAddr(input logic [15:0] addr);
    clint_reg_e sel;
    sel = REG_NONE;
    if (addr[15:3] == CLINT_MSIP_OFF[15:3]) begin
      sel = REG_MSIP;
    end else if (addr[15:3] == CLINT_MTIMECMP_OFF[15:3]) begin
      sel = REG_MTIMECMP;
    end else if (addr[15:3] == CLINT_MTIME_OFF[15:3]) begin
      sel = REG_MTIME;
    end
    return sel;
  endfunction

  // Replace only the bytes whose enable bit is set.
  function automatic logic [63:0] mergeBytes(input logic [63:0] oldVal,
                                             input logic [63:0] newVal,
                                             input logic [7:0]  mask);
    logic [63:0] res;
    res = oldVal;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        res[i*8 +: 8] = newVal[i*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ysyx_040066_clint_timer.sv
// Prescaler plus 64-bit mtime counter. mtime advances by one each time the
// prescaler wraps; a load overrides that cycle's increment, and loads never
// disturb the prescaler phase.
module ysyx_040066_clint_timer #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load_en,
  input  logic [63:0] i_load_val,
  output logic [63:0] o_mtime
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  logic [PW-1:0] r_presc;
  logic [63:0]   r_mtime;
  logic          w_tick;

  assign w_tick  = (r_presc == PRESC_MAX);
  assign o_mtime = r_mtime;

  // Prescaler free-runs 0..CLK_DIV-1 regardless of mtime writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // mtime: a load wins over a coincident tick; increment wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtime <= '0;
    end else if (i_load_en) begin
      r_mtime <= i_load_val;
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

endmodule

// File: rtl/ysyx_040066_clint.sv
// ysyx_040066 CLINT: msip / mtimecmp / mtime behind a valid-ready request
// and response channel with at most one outstanding transaction.
// Optional feature: define YSYX_040066_CLINT_MSIP_EN to implement the msip
// register; without it msip is tied low and offset 0x0000 reads as zero.
module ysyx_040066_clint
  import ysyx_040066_clint_pkg::*;
#(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [15:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        mtip,
  output logic        msip,
  output logic [63:0] mtime
);

  logic        w_accept;
  logic        w_wr;
  clint_reg_e  w_reg;
  logic        w_unmapped;
  logic [63:0] w_mtime;
  logic        w_mtime_load;
  logic [63:0] w_mtime_val;
  logic [63:0] w_rdata;
  logic        w_msip_bit;

  logic [63:0] r_mtimecmp;
  logic        r_mtip;
  logic        r_resp_valid;
  logic [63:0] r_resp_rdata;
  logic        r_resp_err;

  assign req_ready    = !r_resp_valid || resp_ready;
  assign w_accept     = req_valid && req_ready;
  assign w_wr         = w_accept && req_wen;
  assign w_reg        = decodeAddr(req_addr);
  assign w_unmapped   = (w_reg == REG_NONE);
  assign w_mtime_load = w_wr && (w_reg == REG_MTIME);
  assign w_mtime_val  = mergeBytes(w_mtime, req_wdata, req_wmask);

  ysyx_040066_clint_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_load_en (w_mtime_load),
    .i_load_val(w_mtime_val),
    .o_mtime   (w_mtime)
  );

  // mtimecmp: byte-masked write at the acceptance edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtimecmp <= CLINT_MTIMECMP_RST;
    end else if (w_wr && (w_reg == REG_MTIMECMP)) begin
      r_mtimecmp <= mergeBytes(r_mtimecmp, req_wdata, req_wmask);
    end
  end

`ifdef YSYX_040066_CLINT_MSIP_EN
  logic r_msip;

  // msip: only bit 0 exists, written when byte lane 0 is enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_msip <= 1'b0;
    end else if (w_wr && (w_reg == REG_MSIP) && req_wmask[0]) begin
      r_msip <= req_wdata[0];
    end
  end

  assign w_msip_bit = r_msip;
`else
  assign w_msip_bit = 1'b0;
`endif

  // Timer interrupt is a registered compare of the current register values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mtip <= 1'b0;
    end else begin
      r_mtip <= (w_mtime >= r_mtimecmp);
    end
  end

  // Read mux: sampled at acceptance, zero for writes and unmapped offsets.
  always_comb begin
    w_rdata = '0;
    if (!req_wen) begin
      case (w_reg)
        REG_MSIP:     w_rdata = {63'd0, w_msip_bit};
        REG_MTIMECMP: w_rdata = r_mtimecmp;
        REG_MTIME:    w_rdata = w_mtime;
        default:      w_rdata = '0;
      endcase
    end
  end

  // Response holding register: loaded on accept, held until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else if (w_accept) begin
      r_resp_valid <= 1'b1;
      r_resp_rdata <= w_rdata;
      r_resp_err   <= w_unmapped;
    end else if (resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mtip       = r_mtip;
  assign msip       = w_msip_bit;
  assign mtime      = w_mtime;

endmodule

// File: tb/tb_ysyx_040066_clint.sv
// Self-checking bench for ysyx_040066_clint. Two instances share the clock,
// reset and request payload: dutA with CLK_DIV=1 and dutB with CLK_DIV=4.
// Expected responses are queued when a request is driven and popped when
// the response appears. Inputs change and outputs are sampled on negedges.
module tb_ysyx_040066_clint;

`ifdef YSYX_040066_CLINT_MSIP_EN
  localparam logic MSIP_EN = 1'b1;
`else
  localparam logic MSIP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } expT;

  typedef struct packed {
    logic        wen;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] expData;
    logic        expErr;
  } stepT;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqWen;
  logic [15:0] reqAddr;
  logic [63:0] reqWdata;
  logic [7:0]  reqWmask;
  logic        respReady;

  logic        reqValidA, reqReadyA, respValidA, respErrA, mtipA, msipA;
  logic [63:0] respRdataA, mtimeA;
  logic        reqValidB, reqReadyB, respValidB, respErrB, mtipB, msipB;
  logic [63:0] respRdataB, mtimeB;

  int  checks = 0;
  int  errors = 0;
  expT expQ[$];

  always #5 clk = ~clk;

  ysyx_040066_clint #(.CLK_DIV(1)) dutA (
    .clk(clk), .rst(rst),
    .req_valid(reqValidA), .req_ready(reqReadyA), .req_wen(reqWen),
    .req_addr(reqAddr), .req_wdata(reqWdata), .req_wmask(reqWmask),
    .resp_valid(respValidA), .resp_ready(respReady),
    .resp_rdata(respRdataA), .resp_err(respErrA),
    .mtip(mtipA), .msip(msipA), .mtime(mtimeA)
  );

  ysyx_040066_clint #(.CLK_DIV(4)) dutB (
    .clk(clk), .rst(rst),
    .req_valid(reqValidB), .req_ready(reqReadyB), .req_wen(reqWen),
    .req_addr(reqAddr), .req_wdata(reqWdata), .req_wmask(reqWmask),
    .resp_valid(respValidB), .resp_ready(respReady),
    .resp_rdata(respRdataB), .resp_err(respErrB),
    .mtip(mtipB), .msip(msipB), .mtime(mtimeB)
  );

  // Drives one request starting at a negedge, waits (bounded) for
  // acceptance, and returns what the response channel shows one cycle later.
  task automatic busTxn(input bit useB, input logic wen, input logic [15:0] addr,
                        input logic [63:0] wdata, input logic [7:0] wmask,
                        output bit accepted, output logic gotValid,
                        output logic [63:0] gotData, output logic gotErr);
    int waitCnt;
    reqWen   = wen;
    reqAddr  = addr;
    reqWdata = wdata;
    reqWmask = wmask;
    if (useB) reqValidB = 1'b1; else reqValidA = 1'b1;
    accepted = 1'b0;
    waitCnt  = 0;
    while (!accepted && waitCnt < 20) begin
      if ((useB ? reqReadyB : reqReadyA) === 1'b1) begin
        accepted = 1'b1;
        @(posedge clk);
      end else begin
        @(negedge clk);
        waitCnt++;
      end
    end
    if (accepted) @(negedge clk);
    reqValidA = 1'b0;
    reqValidB = 1'b0;
    gotValid  = useB ? respValidB : respValidA;
    gotData   = useB ? respRdataB : respRdataA;
    gotErr    = useB ? respErrB   : respErrA;
  endtask

  // Two reset edges, released at a negedge with no edge since release.
  task automatic doReset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bit acc; logic v, e; logic [63:0] d; expT x;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (mtimeA !== 64'd5) begin errors++; $display("[TB] FAIL run_mtimeA got %h expected %h", mtimeA, 64'd5); end
    checks++; if (mtimeB !== 64'd1) begin errors++; $display("[TB] FAIL run_mtimeB got %h expected %h", mtimeB, 64'd1); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (mtimeA !== 64'd0) begin errors++; $display("[TB] FAIL rst_mtime got %h expected 0", mtimeA); end
    checks++; if (mtipA !== 1'b0) begin errors++; $display("[TB] FAIL rst_mtip got %b expected 0", mtipA); end
    checks++; if (msipA !== 1'b0) begin errors++; $display("[TB] FAIL rst_msip got %b expected 0", msipA); end
    checks++; if (respValidA !== 1'b0) begin errors++; $display("[TB] FAIL rst_resp_valid got %b expected 0", respValidA); end
    checks++; if (respRdataA !== 64'd0) begin errors++; $display("[TB] FAIL rst_resp_rdata got %h expected 0", respRdataA); end
    checks++; if (respErrA !== 1'b0) begin errors++; $display("[TB] FAIL rst_resp_err got %b expected 0", respErrA); end
    rst = 1'b0;
    expQ.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
    busTxn(1'b0, 1'b0, 16'h4000, 64'd0, 8'h00, acc, v, d, e);
    x = expQ.pop_front();
    checks++; if (!acc || v !== 1'b1) begin errors++; $display("[TB] FAIL rst_cmp_valid got %b expected 1", v); end
    checks++; if (d !== x.rdata) begin errors++; $display("[TB] FAIL rst_mtimecmp got %h expected %h", d, x.rdata); end
  endtask

  task automatic test_tick_rate();
    bit acc; logic v, e; logic [63:0] d; expT x;
    doReset();
    repeat (40) @(negedge clk);
    checks++; if (mtimeB !== 64'd10) begin errors++; $display("[TB] FAIL tick_div4 got %0d expected 10", mtimeB); end
    checks++; if (mtimeA !== 64'd40) begin errors++; $display("[TB] FAIL tick_div1 got %0d expected 40", mtimeA); end
    checks++; if (mtipB !== 1'b0) begin errors++; $display("[TB] FAIL tick_mtipB got %b expected 0", mtipB); end
    // Three more edges put the prescaler at its last count, so the read is
    // accepted on a tick edge and must return the pre-increment value.
    repeat (3) @(negedge clk);
    expQ.push_back('{64'd10, 1'b0});
    busTxn(1'b1, 1'b0, 16'hBFF8, 64'd0, 8'h00, acc, v, d, e);
    x = expQ.pop_front();
    checks++; if (!acc || v !== 1'b1) begin errors++; $display("[TB] FAIL tick_read_valid got %b expected 1", v); end
    checks++; if (d !== x.rdata || e !== x.err) begin errors++; $display("[TB] FAIL tick_read got %h/%b expected %h/%b", d, e, x.rdata, x.err); end
    checks++; if (mtimeB !== 64'd11) begin errors++; $display("[TB] FAIL tick_after_read got %0d expected 11", mtimeB); end
  endtask

  task automatic test_compare();
    bit acc; logic v, e; logic [63:0] d; expT x;
    doReset();
    expQ.push_back('{64'd0, 1'b0});
    busTxn(1'b0, 1'b1, 16'h4000, 64'd20, 8'hFF, acc, v, d, e);
    x = expQ.pop_front();
    checks++; if (!acc || v !== 1'b1 || d !== x.rdata || e !== x.err) begin errors++; $display("[TB] FAIL cmp_write got %b/%h/%b expected 1/%h/%b", v, d, e, x.rdata, x.err); end
    repeat (19) @(negedge clk);
    checks++; if (mtimeA !== 64'd20) begin errors++; $display("[TB] FAIL cmp_mtime got %0d expected 20", mtimeA); end
    checks++; if (mtipA !== 1'b0) begin errors++; $display("[TB] FAIL cmp_mtip_lag got %b expected 0", mtipA); end
    @(negedge clk);
    checks++; if (mtipA !== 1'b1) begin errors++; $display("[TB] FAIL cmp_mtip_rise got %b expected 1", mtipA); end
    expQ.push_back('{64'd0, 1'b0});
    busTxn(1'b0, 1'b1, 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, acc, v, d, e);
    x = expQ.pop_front();
    checks++; if (!acc || v !== 1'b1 || d !== x.rdata || e !== x.err) begin errors++; $display("[TB] FAIL cmp_write_max got %b/%h/%b expected 1/%h/%b", v, d, e, x.rdata, x.err); end
    checks++; if (mtipA !== 1'b1) begin errors++; $display("[TB] FAIL cmp_mtip_hold got %b expected 1", mtipA); end
    @(negedge clk);
    checks++; if (mtipA !== 1'b0) begin errors++; $display("[TB] FAIL cmp_mtip_drop got %b expected 0", mtipA); end
  endtask

  task automatic test_wrap();
    bit acc; logic v, e; logic [63:0] d;
    busTxn(1'b0, 1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, acc, v, d, e);
    checks++; if (!acc || mtimeA !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("[TB] FAIL wrap_load got %h expected fffffffffffffffe", mtimeA); end
    @(negedge clk);
    checks++; if (mtimeA !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("[TB] FAIL wrap_max got %h expected ffffffffffffffff", mtimeA); end
    @(negedge clk);
    checks++; if (mtimeA !== 64'd0) begin errors++; $display("[TB] FAIL wrap_zero got %h expected 0", mtimeA); end
    // With CLK_DIV=1 every edge is a tick, so this load collides with one.
    busTxn(1'b0, 1'b1, 16'hBFF8, 64'h1234, 8'hFF, acc, v, d, e);
    checks++; if (!acc || mtimeA !== 64'h1234) begin errors++; $display("[TB] FAIL wrap_collision got %h expected 1234", mtimeA); end
  endtask

  task automatic test_partial();
    stepT steps[4];
    bit acc; logic v, e; logic [63:0] d; expT x;
    steps[0] = '{1'b1, 16'h4000, 64'h1122_3344_5566_7788, 8'hFF, 64'd0, 1'b0};
    steps[1] = '{1'b1, 16'h4000, 64'hAAAA_AAAA_AAAA_AAAA, 8'h01, 64'd0, 1'b0};
    steps[2] = '{1'b0, 16'h4000, 64'd0, 8'h00, 64'h1122_3344_5566_77AA, 1'b0};
    steps[3] = '{1'b0, 16'h4005, 64'd0, 8'h00, 64'h1122_3344_5566_77AA, 1'b0};
    for (int i = 0; i < 4; i++) begin
      expQ.push_back('{steps[i].expData, steps[i].expErr});
      busTxn(1'b0, steps[i].wen, steps[i].addr, steps[i].wdata, steps[i].wmask, acc, v, d, e);
      x = expQ.pop_front();
      checks++; if (!acc || v !== 1'b1 || d !== x.rdata || e !== x.err) begin errors++; $display("[TB] FAIL partial_%0d got %b/%h/%b expected 1/%h/%b", i, v, d, e, x.rdata, x.err); end
    end
  endtask

  task automatic test_back_to_back();
    stepT steps[5];
    bit acc; logic v, e; logic [63:0] d; expT x;
    steps[0] = '{1'b1, 16'hBFF8, 64'd100, 8'hFF, 64'd0, 1'b0};
    steps[1] = '{1'b0, 16'hBFF8, 64'd0, 8'h00, 64'd100, 1'b0};
    steps[2] = '{1'b0, 16'h4000, 64'd0, 8'h00, 64'h1122_3344_5566_77AA, 1'b0};
    steps[3] = '{1'b1, 16'h8000, 64'hDEAD, 8'hFF, 64'd0, 1'b1};
    steps[4] = '{1'b0, 16'hBFFF, 64'd0, 8'h00, 64'd103, 1'b0};
    for (int i = 0; i < 5; i++) expQ.push_back('{steps[i].expData, steps[i].expErr});
    for (int i = 0; i < 5; i++) begin
      busTxn(1'b0, steps[i].wen, steps[i].addr, steps[i].wdata, steps[i].wmask, acc, v, d, e);
      x = expQ.pop_front();
      checks++; if (!acc || v !== 1'b1 || d !== x.rdata || e !== x.err) begin errors++; $display("[TB] FAIL b2b_%0d got %b/%h/%b expected 1/%h/%b", i, v, d, e, x.rdata, x.err); end
    end
  endtask

  task automatic test_backpressure();
    bit acc; logic v, e; logic [63:0] d; expT x;
    @(negedge clk);
    respReady = 1'b0;
    expQ.push_back('{64'h1122_3344_5566_77AA, 1'b0});
    busTxn(1'b0, 1'b0, 16'h4000, 64'd0, 8'h00, acc, v, d, e);
    x = expQ.pop_front();
    checks++; if (!acc || v !== 1'b1 || d !== x.rdata) begin errors++; $display("[TB] FAIL bp_first got %b/%h expected 1/%h", v, d, x.rdata); end
    // A competing write must be held off while the response is stalled.
    reqValidA = 1'b1; reqWen = 1'b1; reqAddr = 16'h4000; reqWdata = 64'd0; reqWmask = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      checks++; if (reqReadyA !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_%0d got %b expected 0", i, reqReadyA); end
      checks++; if (respValidA !== 1'b1 || respRdataA !== x.rdata || respErrA !== 1'b0) begin errors++; $display("[TB] FAIL bp_stable_%0d got %b/%h/%b expected 1/%h/0", i, respValidA, respRdataA, respErrA, x.rdata); end
      @(negedge clk);
    end
    reqValidA = 1'b0;
    respReady = 1'b1;
    @(negedge clk);
    checks++; if (respValidA !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain got %b expected 0", respValidA); end
    expQ.push_back('{64'h1122_3344_5566_77AA, 1'b0});
    busTxn(1'b0, 1'b0, 16'h4000, 64'd0, 8'h00, acc, v, d, e);
    x = expQ.pop_front();
    checks++; if (!acc || v !== 1'b1 || d !== x.rdata || e !== x.err) begin errors++; $display("[TB] FAIL bp_no_write got %b/%h/%b expected 1/%h/%b", v, d, e, x.rdata, x.err); end
    expQ.push_back('{64'd0, 1'b1});
    busTxn(1'b0, 1'b0, 16'h1000, 64'd0, 8'h00, acc, v, d, e);
    x = expQ.pop_front();
    checks++; if (!acc || v !== 1'b1 || d !== x.rdata || e !== x.err) begin errors++; $display("[TB] FAIL bp_unmapped got %b/%h/%b expected 1/%h/%b", v, d, e, x.rdata, x.err); end
  endtask

  task automatic test_reset_mid();
    bit acc; logic v, e; logic [63:0] d; expT x;
    @(negedge clk);
    expQ.push_back('{64'd0, 1'b1});
    busTxn(1'b0, 1'b0, 16'h1000, 64'd0, 8'h00, acc, v, d, e);
    respReady = 1'b0;
    x = expQ.pop_front();
    checks++; if (!acc || v !== 1'b1 || e !== x.err) begin errors++; $display("[TB] FAIL rmid_pending got %b/%b expected 1/%b", v, e, x.err); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (respValidA !== 1'b0) begin errors++; $display("[TB] FAIL rmid_valid got %b expected 0", respValidA); end
    checks++; if (respErrA !== 1'b0) begin errors++; $display("[TB] FAIL rmid_err got %b expected 0", respErrA); end
    checks++; if (mtimeA !== 64'd0) begin errors++; $display("[TB] FAIL rmid_mtime got %h expected 0", mtimeA); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (reqReadyA !== 1'b1) begin errors++; $display("[TB] FAIL rmid_ready got %b expected 1", reqReadyA); end
    checks++; if (mtimeA !== 64'd1) begin errors++; $display("[TB] FAIL rmid_restart got %h expected 1", mtimeA); end
    respReady = 1'b1;
  endtask

  task automatic test_msip();
    stepT steps[8];
    logic expMsip[8];
    bit acc; logic v, e; logic [63:0] d; expT x;
    doReset();
    steps[0] = '{1'b1, 16'h0000, 64'd1, 8'h01, 64'd0, 1'b0};                     expMsip[0] = MSIP_EN;
    steps[1] = '{1'b0, 16'h0000, 64'd0, 8'h00, {63'd0, MSIP_EN}, 1'b0};           expMsip[1] = MSIP_EN;
    steps[2] = '{1'b1, 16'h0000, 64'd0, 8'h00, 64'd0, 1'b0};                      expMsip[2] = MSIP_EN;
    steps[3] = '{1'b0, 16'h0004, 64'd0, 8'h00, {63'd0, MSIP_EN}, 1'b0};           expMsip[3] = MSIP_EN;
    steps[4] = '{1'b1, 16'h0000, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 64'd0, 1'b0};   expMsip[4] = 1'b0;
    steps[5] = '{1'b0, 16'h0000, 64'd0, 8'h00, 64'd0, 1'b0};                      expMsip[5] = 1'b0;
    steps[6] = '{1'b1, 16'h0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'd0, 1'b0};   expMsip[6] = MSIP_EN;
    steps[7] = '{1'b0, 16'h0000, 64'd0, 8'h00, {63'd0, MSIP_EN}, 1'b0};           expMsip[7] = MSIP_EN;
    for (int i = 0; i < 8; i++) begin
      expQ.push_back('{steps[i].expData, steps[i].expErr});
      busTxn(1'b0, steps[i].wen, steps[i].addr, steps[i].wdata, steps[i].wmask, acc, v, d, e);
      x = expQ.pop_front();
      checks++; if (!acc || v !== 1'b1 || d !== x.rdata || e !== x.err) begin errors++; $display("[TB] FAIL msip_resp_%0d got %b/%h/%b expected 1/%h/%b", i, v, d, e, x.rdata, x.err); end
      checks++; if (msipA !== expMsip[i]) begin errors++; $display("[TB] FAIL msip_pin_%0d got %b expected %b", i, msipA, expMsip[i]); end
    end
    checks++; if (msipB !== 1'b0) begin errors++; $display("[TB] FAIL msip_untouched got %b expected 0", msipB); end
  endtask

  // Scenario sequence; every task begins and ends on a negedge.
  initial begin
    rst = 1'b1; reqValidA = 1'b0; reqValidB = 1'b0; reqWen = 1'b0;
    reqAddr = '0; reqWdata = '0; reqWmask = '0; respReady = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_tick_rate();
    test_compare();
    test_wrap();
    test_partial();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_msip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guards against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
